// File: rtl/selector41_scan_ctrl_if.sv
// rtl/selector41_scan_ctrl_if.sv - selector scan controller bus; adds chg when SCAN_CHG_EN is defined
interface selector41_scan_ctrl_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic             cont;
  logic [WIDTH-1:0] z;
  logic             s1;
  logic             s0;
  logic [WIDTH-1:0] ch0;
  logic [WIDTH-1:0] ch1;
  logic [WIDTH-1:0] ch2;
  logic [WIDTH-1:0] ch3;
  logic             valid;
  logic [1:0]       ch_idx;
  logic             busy;
  logic             done;
`ifdef SCAN_CHG_EN
  logic [3:0]       chg;

  modport master (
    output start, cont, z,
    input  s1, s0, ch0, ch1, ch2, ch3, valid, ch_idx, busy, done, chg
  );

  modport slave (
    input  start, cont, z,
    output s1, s0, ch0, ch1, ch2, ch3, valid, ch_idx, busy, done, chg
  );
`else
  modport master (
    output start, cont, z,
    input  s1, s0, ch0, ch1, ch2, ch3, valid, ch_idx, busy, done
  );

  modport slave (
    input  start, cont, z,
    output s1, s0, ch0, ch1, ch2, ch3, valid, ch_idx, busy, done
  );
`endif
endinterface

// File: rtl/selector41_scan_ctrl.sv
// rtl/selector41_scan_ctrl.sv - 4-to-1 selector scan sequencer and capture stage; optional SCAN_CHG_EN change flags
module selector41_scan_ctrl #(
  parameter int WIDTH = 4,
  parameter int DWELL = 4
) (
  input logic                  clk,
  input logic                  rst_n,
  selector41_scan_ctrl_if.slave bus
);

  // Dwell below 2 leaves no settle cycle, so clamp it; the counter is 8 bits wide.
  localparam int         DW_EFF = (DWELL < 2) ? 2 : ((DWELL > 255) ? 255 : DWELL);
  localparam logic [7:0] LAST   = 8'(DW_EFF - 1);

  typedef enum logic {
    IDLE,
    SCAN
  } state_t;

  state_t           state;
  logic [1:0]       chan;
  logic [7:0]       cnt;
  logic [WIDTH-1:0] ch_q [4];
  logic             valid_q;
  logic             done_q;
  logic             busy_q;
  logic [1:0]       idx_q;
`ifdef SCAN_CHG_EN
  logic [3:0]       chg_q;
`endif

  // Sequencer: chan doubles as the registered select value, so selects only move on advance edges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      chan    <= 2'd0;
      cnt     <= 8'd0;
      ch_q[0] <= '0;
      ch_q[1] <= '0;
      ch_q[2] <= '0;
      ch_q[3] <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      idx_q   <= 2'd0;
`ifdef SCAN_CHG_EN
      chg_q   <= 4'd0;
`endif
    end else begin
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      case (state)
        IDLE: begin
          chan <= 2'd0;
          cnt  <= 8'd0;
          if (bus.start) begin
            state  <= SCAN;
            busy_q <= 1'b1;
          end
        end
        SCAN: begin
          if (cnt == LAST) begin
            cnt        <= 8'd0;
            ch_q[chan] <= bus.z;
            valid_q    <= 1'b1;
            idx_q      <= chan;
`ifdef SCAN_CHG_EN
            chg_q[chan] <= (bus.z != ch_q[chan]);
`endif
            // Channel 3 wraps to 0 naturally, which is also the idle select value.
            chan <= chan + 2'd1;
            if (chan == 2'd3) begin
              done_q <= 1'b1;
              if (!bus.cont) begin
                state  <= IDLE;
                busy_q <= 1'b0;
              end
            end
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.s1     = chan[1];
  assign bus.s0     = chan[0];
  assign bus.ch0    = ch_q[0];
  assign bus.ch1    = ch_q[1];
  assign bus.ch2    = ch_q[2];
  assign bus.ch3    = ch_q[3];
  assign bus.valid  = valid_q;
  assign bus.ch_idx = idx_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
`ifdef SCAN_CHG_EN
  assign bus.chg    = chg_q;
`endif

endmodule
